// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - servo timing constants and the pulse FSM state type
package servo_pkg;
  localparam int SERVO_CENTRE_US = 1500;
  localparam int SERVO_MIN_US    = 500;
  localparam int SERVO_MAX_US    = 2500;
  localparam int SERVO_FRAME_US  = 20000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } servo_state_e;
endpackage

// File: rtl/us_tick_gen.sv
// rtl/us_tick_gen.sv - 1 us tick prescaler, restartable so a measurement starts on a tick boundary
module us_tick_gen #(
  parameter int CLK_MHZ = 100
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic tick
);
  localparam int W = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_MHZ - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);
endmodule

// File: rtl/servo_pulse_decoder.sv
// rtl/servo_pulse_decoder.sv - measures RC servo pulse high width in us, flags range errors and signal loss
module servo_pulse_decoder
  import servo_pkg::*;
#(
  parameter int CLK_MHZ          = 100,
  parameter int MIN_US           = SERVO_MIN_US,
  parameter int MAX_US           = SERVO_MAX_US,
  parameter int FRAME_TIMEOUT_US = 25000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SERVO_IN,
  output logic [15:0] pulse_len,
  output logic        pulse_valid,
  output logic        range_err,
  output logic        signal_lost
);
  localparam int FW = $clog2(FRAME_TIMEOUT_US + 1);
  localparam logic [FW-1:0] FRAME_LIMIT = FW'(FRAME_TIMEOUT_US);
  localparam bit            STUCK_EN    = (FRAME_TIMEOUT_US <= 65535);
  localparam logic [15:0]   WIDTH_LIMIT = 16'(FRAME_TIMEOUT_US);
  localparam logic [15:0]   MIN_W       = 16'(MIN_US);
  localparam logic [15:0]   MAX_W       = 16'(MAX_US);

  logic [2:0]    sync_q, sync_d;
  servo_state_e  state_q, state_d;
  logic [15:0]   width_q, width_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [15:0]   len_q, len_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          lost_q, lost_d;
  logic          in_s, rise, fall, tick;

  assign sync_d = {sync_q[1:0], SERVO_IN};
  assign in_s   = sync_q[1];
  assign rise   = sync_q[1] & ~sync_q[2];
  assign fall   = ~sync_q[1] & sync_q[2];

  us_tick_gen #(.CLK_MHZ(CLK_MHZ)) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (rise),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    width_d = width_q;
    frame_d = frame_q;
    len_d   = len_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    lost_d  = lost_q;

    if (tick && frame_q != FRAME_LIMIT) frame_d = frame_q + 1'b1;
    if (frame_q == FRAME_LIMIT) lost_d = 1'b1;

    case (state_q)
      IDLE: if (!in_s) state_d = LOW;
      LOW: begin
        if (rise) begin
          state_d = HIGH;
          width_d = '0;
        end
      end
      HIGH: begin
        if (tick && width_q != 16'hFFFF) width_d = width_q + 1'b1;
        // A stuck-high line beats a coincident fall: the pulse is abandoned unreported.
        if (STUCK_EN && width_q == WIDTH_LIMIT) begin
          state_d = IDLE;
          lost_d  = 1'b1;
        end else if (fall) begin
          state_d = LOW;
          if (width_q >= MIN_W && width_q <= MAX_W) begin
            len_d   = width_q;
            valid_d = 1'b1;
            lost_d  = 1'b0;
            frame_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Synchroniser resets high so a pulse already in progress at reset is never seen as a rise.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q  <= 3'b111;
      state_q <= IDLE;
      width_q <= '0;
      frame_q <= '0;
      len_q   <= 16'(SERVO_CENTRE_US);
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      lost_q  <= 1'b1;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      width_q <= width_d;
      frame_q <= frame_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      lost_q  <= lost_d;
    end
  end

  assign pulse_len   = len_q;
  assign pulse_valid = valid_q;
  assign range_err   = err_q;
  assign signal_lost = lost_q;
endmodule

// File: tb/tb_servo_pulse_decoder.sv
// tb/tb_servo_pulse_decoder.sv - directed bench for servo_pulse_decoder with scaled timing (2 MHz, 1 ms timeout)
module tb_servo_pulse_decoder;
  localparam int C  = 2;
  localparam int TO = 1000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        SERVO_IN;
  logic [15:0] pulse_len;
  logic        pulse_valid;
  logic        range_err;
  logic        signal_lost;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_err = 0;
  int both_seen = 0;
  int v0, e0, len0;

  typedef struct {
    int hi_cyc;
    bit exp_ok;
    int lo_us;
    int hi_us;
  } vec_t;
  vec_t vecs[9];

  always #5 CLK = ~CLK;

  servo_pulse_decoder #(
    .CLK_MHZ(C), .MIN_US(50), .MAX_US(250), .FRAME_TIMEOUT_US(TO)
  ) dut (
    .CLK(CLK), .RST(RST), .SERVO_IN(SERVO_IN),
    .pulse_len(pulse_len), .pulse_valid(pulse_valid),
    .range_err(range_err), .signal_lost(signal_lost)
  );

  always @(negedge CLK) begin
    if (pulse_valid) n_valid++;
    if (range_err) n_err++;
    if (pulse_valid && range_err) both_seen++;
  end

  task automatic check(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic pulse(input int hi_cyc, input int lo_cyc);
    @(negedge CLK);
    SERVO_IN = 1'b1;
    repeat (hi_cyc) @(negedge CLK);
    SERVO_IN = 1'b0;
    repeat (lo_cyc) @(negedge CLK);
  endtask

  task automatic snap();
    v0 = n_valid;
    e0 = n_err;
    len0 = int'(pulse_len);
  endtask

  initial begin
    // high cycles at 2 cycles/us; odd counts land on an exact us after truncation
    vecs[0] = '{300, 1'b1, 149, 150};
    vecs[1] = '{80,  1'b0, 0, 0};
    vecs[2] = '{600, 1'b0, 0, 0};
    vecs[3] = '{101, 1'b1, 50, 50};
    vecs[4] = '{99,  1'b0, 0, 0};
    vecs[5] = '{501, 1'b1, 250, 250};
    vecs[6] = '{503, 1'b0, 0, 0};
    vecs[7] = '{200, 1'b1, 99, 100};
    vecs[8] = '{400, 1'b1, 199, 200};

    RST = 1'b1;
    SERVO_IN = 1'b0;
    #1;
    check("reset pulse_len", int'(pulse_len), 1500, 1500);
    check("reset pulse_valid", int'(pulse_valid), 0, 0);
    check("reset range_err", int'(range_err), 0, 0);
    check("reset signal_lost", int'(signal_lost), 1, 1);
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    repeat (10) @(negedge CLK);

    // strobe timing relative to the input fall
    snap();
    @(negedge CLK);
    SERVO_IN = 1'b1;
    repeat (300) @(negedge CLK);
    SERVO_IN = 1'b0;
    @(negedge CLK); check("latency cycle1", int'(pulse_valid), 0, 0);
    @(negedge CLK); check("latency cycle2", int'(pulse_valid), 0, 0);
    @(negedge CLK); check("latency cycle3", int'(pulse_valid), 1, 1);
    @(negedge CLK); check("latency cycle4", int'(pulse_valid), 0, 0);
    repeat (100) @(negedge CLK);
    check("first len", int'(pulse_len), 149, 150);
    check("first lost", int'(signal_lost), 0, 0);
    check("first one strobe", n_valid - v0, 1, 1);

    for (int i = 0; i < 9; i++) begin
      snap();
      pulse(vecs[i].hi_cyc, 200);
      if (vecs[i].exp_ok) begin
        check($sformatf("vec%0d valid", i), n_valid - v0, 1, 1);
        check($sformatf("vec%0d no err", i), n_err - e0, 0, 0);
        check($sformatf("vec%0d len", i), int'(pulse_len), vecs[i].lo_us, vecs[i].hi_us);
        check($sformatf("vec%0d lost", i), int'(signal_lost), 0, 0);
      end else begin
        check($sformatf("vec%0d no valid", i), n_valid - v0, 0, 0);
        check($sformatf("vec%0d err", i), n_err - e0, 1, 1);
        check($sformatf("vec%0d len held", i), int'(pulse_len), len0, len0);
      end
    end

    // frame timeout counted from the accepted pulse
    @(negedge CLK);
    SERVO_IN = 1'b1;
    repeat (200) @(negedge CLK);
    SERVO_IN = 1'b0;
    repeat (3) @(negedge CLK);
    check("timeout base lost", int'(signal_lost), 0, 0);
    repeat (C * (TO - 5)) @(negedge CLK);
    check("timeout early", int'(signal_lost), 0, 0);
    repeat (C * 10) @(negedge CLK);
    check("timeout late", int'(signal_lost), 1, 1);
    snap();
    pulse(300, 200);
    check("recover valid", n_valid - v0, 1, 1);
    check("recover lost", int'(signal_lost), 0, 0);

    // stuck high, then a normal pulse
    snap();
    @(negedge CLK);
    SERVO_IN = 1'b1;
    repeat (C * 1200) @(negedge CLK);
    check("stuck lost", int'(signal_lost), 1, 1);
    SERVO_IN = 1'b0;
    repeat (200) @(negedge CLK);
    check("stuck no valid", n_valid - v0, 0, 0);
    check("stuck no err", n_err - e0, 0, 0);
    check("stuck len held", int'(pulse_len), len0, len0);
    snap();
    pulse(240, 200);
    check("after stuck valid", n_valid - v0, 1, 1);
    check("after stuck len", int'(pulse_len), 119, 120);
    check("after stuck lost", int'(signal_lost), 0, 0);

    // reset in the middle of a pulse, released while still high
    snap();
    @(negedge CLK);
    SERVO_IN = 1'b1;
    repeat (160) @(negedge CLK);
    RST = 1'b1;
    #1;
    check("midrst len", int'(pulse_len), 1500, 1500);
    check("midrst lost", int'(signal_lost), 1, 1);
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    repeat (200) @(negedge CLK);
    SERVO_IN = 1'b0;
    repeat (200) @(negedge CLK);
    check("midrst no valid", n_valid - v0, 0, 0);
    check("midrst no err", n_err - e0, 0, 0);
    check("midrst len kept", int'(pulse_len), 1500, 1500);
    snap();
    pulse(300, 200);
    check("midrst next valid", n_valid - v0, 1, 1);
    check("midrst next len", int'(pulse_len), 149, 150);

    // generator-style frames of 400 us
    for (int w = 100; w <= 200; w += 10) begin
      snap();
      pulse(C * w, C * (400 - w));
      check($sformatf("loop%0d one strobe", w), n_valid - v0, 1, 1);
      check($sformatf("loop%0d no err", w), n_err - e0, 0, 0);
      check($sformatf("loop%0d len", w), int'(pulse_len), w - 1, w);
    end

    check("valid and err exclusive", both_seen, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
